// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Holds the last result on bcd for the downstream 7-segment scan stage.
module bin2bcd_seq #(
  parameter int BIN_W  = 21,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t              state_q;
  logic [WORK_W-1:0]   work_q;
  logic [WORK_W-1:0]   work_d;
  logic [WORK_W-1:0]   corr;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                valid_q;
  logic [BCD_W-1:0]    bcd_q;

  // All nibbles are corrected from the pre-edge value, then the whole word shifts.
  always_comb begin
    corr = work_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (work_q[BIN_W + 4*d +: 4] >= 4'd5)
        corr[BIN_W + 4*d +: 4] = work_q[BIN_W + 4*d +: 4] + 4'd3;
    end
    work_d = corr << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q  <= {{BCD_W{1'b0}}, bin};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1))
            state_q <= FINISH;
        end
        FINISH: begin
          bcd_q   <= work_q[WORK_W-1 -: BCD_W];
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_valid = valid_q;
  assign bcd       = bcd_q;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 7-segment scan/display stage.
- Converts the 21-bit DDS frequency/value word into seven packed BCD digits using shift-and-add-3 (double dabble), one bit per clock.
- Replaces per-digit divide/modulo logic in the display path; the display stage indexes ready-made BCD nibbles.
- Start/busy/done handshake; the last result is held stable for continuous display.

Parameters:
- BIN_W, 21, width of binary input.
- DIGITS, 7, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; the defaults meet this, so overflow cannot occur.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request, sampled on rising edge.
- bin  input  BIN_W  binary value, latched when start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: bcd has just been updated.
- bcd_valid  output  1  high once any conversion has completed since reset.
- bcd  output  4*DIGITS  packed BCD; digit0 (units) = bcd[3:0], digit6 = bcd[27:24].

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE; busy = 0, done = 0, bcd_valid = 0, bcd = 0.
  - Internal shift register and bit counter cleared.
  - Any conversion in flight is abandoned.
- Internal work register: {DIGITS*4 BCD bits, BIN_W binary bits}. Bit counter width is ceil(log2(BIN_W)).
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - On an edge with start = 1: load work = {0, bin}, counter = 0, busy <= 1, go to SHIFT.
  - With start = 0: hold. done is driven 0 in every state except the cycle after FINISH.
- SHIFT, each edge:
  - First, every BCD nibble >= 5 gets +3; all nibbles are corrected in parallel from the pre-edge value.
  - Then shift the whole work register left by 1; counter += 1.
  - On the edge where counter == BIN_W-1 (i.e. the BIN_W-th shift), go to FINISH.
- FINISH, one edge:
  - bcd <= BCD field of work; done <= 1; bcd_valid <= 1; busy <= 0; go to IDLE.
- Latency:
  - Start sampled at edge E0.
  - BIN_W shifts on edges E1..E21.
  - FINISH executes at E22; done and new bcd are visible after E22, i.e. BIN_W+1 cycles after the accepting edge.
- done is high for exactly one cycle per conversion.
- bcd changes only at the FINISH edge. It holds its value between conversions and during the next conversion, so the display never sees intermediate values.
- start while busy (SHIFT or FINISH): ignored, no queuing. bin changes during busy have no effect.
- start high in the cycle done is high: state is IDLE, so it is accepted at that edge. Back-to-back conversions run every BIN_W+2 cycles.
- start held high continuously: the block auto-restarts immediately after each completion, usable as free-running refresh.
- All arithmetic is unsigned. Nibble correction is a 4-bit add with no carry out; it never exceeds 4 bits because nibble <= 9 before correction.

Test Plan:
- Reset, then bin = 0 with start pulse -> busy high for 22 cycles (E1..E22 inclusive), done pulse after E22, bcd = 28'h0000000, bcd_valid = 1.
- bin = 1234567 -> bcd = 28'h1234567. bin = 2097151 (max) -> bcd = 28'h2097151. bin = 9 then 10 -> bcd = 28'h0000009, then 28'h0000010.
- Start with bin = 500000; at cycle 5 pulse start with bin = 777 and change bin every cycle -> second start ignored; single done; bcd = 28'h0500000.
- Assert rst_n low at cycle 10 of a conversion, release, then convert 42 -> outputs 0 and bcd_valid = 0 during reset, no done pulse from the aborted run; next conversion gives bcd = 28'h0000042.
- Hold start = 1 with bin stepping 100, 101, 102 per conversion -> done every 23 cycles, bcd = 28'h0000100, 28'h0000101, 28'h0000102; bcd stable between done pulses.
- Random regression, 1000 values in 0..2097151 -> each digit equals (bin/10^k)%10, checked against a software model.
